// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for a 16-bit core.
// Optional feature macro CU_HALT_EN adds a HALT state entered on instruction 16'hFFFF.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] pc,
  input  logic [15:0] alu_r,
  input  logic        alu_cmp,
  output logic [2:0]  codeop,
  output logic        ri,
  output logic        ld,
  output logic        jmp,
  output logic [2:0]  rd_idx,
  output logic [2:0]  ra_idx,
  output logic [2:0]  rb_idx,
  output logic [15:0] imm,
  output logic        reg_we,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        halted
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
`ifdef CU_HALT_EN
  localparam logic [2:0] S_HALT   = 3'd5;
`endif

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_LD  = 2'b01;
  localparam logic [1:0] CLS_ST  = 2'b10;
  localparam logic [1:0] CLS_JMP = 2'b11;

  logic [2:0]  state_r;
  logic [2:0]  state_s;
  logic [15:0] ir_r;
  logic [1:0]  cls_r;
  logic        take_jump_s;

  // Next-state logic; acks only matter in the state that is waiting for them.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (imem_ack) state_s = S_DECODE;
        else          state_s = S_FETCH;
      end
      S_DECODE: begin
`ifdef CU_HALT_EN
        if (ir_r == 16'hFFFF) state_s = S_HALT;
        else                  state_s = S_EXEC;
`else
        state_s = S_EXEC;
`endif
      end
      S_EXEC: begin
        if ((cls_r == CLS_LD) || (cls_r == CLS_ST)) state_s = S_MEM;
        else                                        state_s = S_WB;
      end
      S_MEM: begin
        if (dmem_ack) state_s = S_WB;
        else          state_s = S_MEM;
      end
      S_WB: state_s = S_FETCH;
`ifdef CU_HALT_EN
      S_HALT: state_s = S_HALT;
`endif
      default: state_s = S_FETCH;
    endcase
  end

  assign take_jump_s = jmp & alu_cmp;

  // State, instruction register and program counter; reset aborts any pending update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
      ir_r    <= 16'h0000;
      pc      <= 16'h0000;
    end else begin
      state_r <= state_s;
      if ((state_r == S_FETCH) && imem_ack) begin
        ir_r <= imem_data;
      end
      if (state_r == S_WB) begin
        pc <= take_jump_s ? alu_r : (pc + 16'h0001);
      end
    end
  end

  // Decoded fields are captured once in DECODE and held until the next DECODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      codeop <= 3'b000;
      ri     <= 1'b0;
      cls_r  <= CLS_ALU;
      ld     <= 1'b0;
      jmp    <= 1'b0;
      rd_idx <= 3'b000;
      ra_idx <= 3'b000;
      rb_idx <= 3'b000;
      imm    <= 16'h0000;
    end else if (state_r == S_DECODE) begin
      codeop <= ir_r[15:13];
      ri     <= ir_r[12];
      cls_r  <= ir_r[11:10];
      ld     <= (ir_r[11:10] == CLS_LD);
      jmp    <= (ir_r[11:10] == CLS_JMP);
      rd_idx <= ir_r[9:7];
      ra_idx <= ir_r[6:4];
      rb_idx <= ir_r[3:1];
      imm    <= {{12{ir_r[3]}}, ir_r[3:0]};
    end
  end

  // Strobes are pure state decodes, forced low while reset is asserted.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      reg_we   = 1'b0;
    end else begin
      imem_req = (state_r == S_FETCH);
      dmem_req = (state_r == S_MEM);
      dmem_we  = (state_r == S_MEM) && (cls_r == CLS_ST);
      reg_we   = (state_r == S_WB) && ((cls_r == CLS_ALU) || (cls_r == CLS_LD));
    end
  end

`ifdef CU_HALT_EN
  assign halted = (state_r == S_HALT) && !rst;
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expectations go through a scoreboard queue.
// Covers ALU/LD/ST/JMP timing, pc wrap, ignored acks, reset in MEM and the CU_HALT_EN behaviour.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] pc;
  logic [15:0] alu_r;
  logic        alu_cmp;
  logic [2:0]  codeop;
  logic        ri, ld, jmp;
  logic [2:0]  rd_idx, ra_idx, rb_idx;
  logic [15:0] imm;
  logic        reg_we, dmem_req, dmem_we, dmem_ack, halted;

  control_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .pc(pc), .alu_r(alu_r), .alu_cmp(alu_cmp),
    .codeop(codeop), .ri(ri), .ld(ld), .jmp(jmp),
    .rd_idx(rd_idx), .ra_idx(ra_idx), .rb_idx(rb_idx), .imm(imm),
    .reg_we(reg_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    int          cyc;
    int          nwe;
    int          we_at;
    int          nd;
    logic        dwe;
    logic        ld;
    logic        jmp;
    logic [2:0]  codeop;
    logic        ri;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] imm;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] pc_model;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one instruction starting at a negedge in FETCH; returns at the negedge of the next FETCH.
  task automatic exec_instr(input logic [15:0] instr, input int idly, input int dly,
                            input logic [15:0] ar, input logic cmp, input logic noise);
    exp_t e;
    exp_t o;
    logic [1:0] c;
    logic mem, done, seen_low;
    int nf;
    c = instr[11:10];
    mem = (c == 2'b01) || (c == 2'b10);
    e.pc     = ((c == 2'b11) && cmp) ? ar : (pc_model + 16'd1);
    e.cyc    = 4 + idly + (mem ? (dly + 1) : 0);
    e.nwe    = ((c == 2'b00) || (c == 2'b01)) ? 1 : 0;
    e.we_at  = (e.nwe == 1) ? e.cyc : 0;
    e.nd     = mem ? (dly + 1) : 0;
    e.dwe    = (c == 2'b10);
    e.ld     = (c == 2'b01);
    e.jmp    = (c == 2'b11);
    e.codeop = instr[15:13];
    e.ri     = instr[12];
    e.rd     = instr[9:7];
    e.ra     = instr[6:4];
    e.rb     = instr[3:1];
    e.imm    = {{12{instr[3]}}, instr[3:0]};
    sb.push_back(e);

    o = e;
    o.cyc = 0; o.nwe = 0; o.we_at = 0; o.nd = 0; o.dwe = 1'b0;
    done = 1'b0; seen_low = 1'b0; nf = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      if (imem_req && seen_low) begin
        done = 1'b1;
      end else begin
        if (!imem_req) seen_low = 1'b1;
        o.cyc++;
        if (imem_req) nf++;
        if (reg_we) begin o.nwe++; o.we_at = o.cyc; end
        if (dmem_req) begin o.nd++; if (dmem_we) o.dwe = 1'b1; end
        o.ld = ld; o.jmp = jmp; o.codeop = codeop; o.ri = ri;
        o.rd = rd_idx; o.ra = ra_idx; o.rb = rb_idx; o.imm = imm;
        imem_data = instr;
        alu_r     = ar;
        alu_cmp   = cmp;
        imem_ack  = imem_req ? (nf == idly + 1) : noise;
        dmem_ack  = dmem_req ? (o.nd == dly + 1) : noise;
        @(negedge clk);
      end
    end
    if (!done) check_val("timeout", 32'd0, 32'd1);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;

    e = sb.pop_front();
    check_val("cycles",   o.cyc,    e.cyc);
    check_val("reg_we_n", o.nwe,    e.nwe);
    check_val("reg_we_at", o.we_at, e.we_at);
    check_val("dmem_req_n", o.nd,   e.nd);
    check_val("dmem_we",  o.dwe,    e.dwe);
    check_val("ld",       o.ld,     e.ld);
    check_val("jmp",      o.jmp,    e.jmp);
    check_val("codeop",   o.codeop, e.codeop);
    check_val("ri",       o.ri,     e.ri);
    check_val("rd_idx",   o.rd,     e.rd);
    check_val("ra_idx",   o.ra,     e.ra);
    check_val("rb_idx",   o.rb,     e.rb);
    check_val("imm",      o.imm,    e.imm);
    check_val("pc",       pc,       e.pc);
    check_val("halted",   halted,   1'b0);
    pc_model = e.pc;
  endtask

  initial begin
    int n;
    rst = 1'b1; imem_ack = 1'b0; imem_data = 16'h0000;
    alu_r = 16'h0000; alu_cmp = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_outs", {imem_req, dmem_req, dmem_we, reg_we, halted, ld, jmp, ri,
                           codeop, rd_idx, ra_idx, rb_idx}, 32'd0);
    check_val("rst_pc", pc, 16'h0000);
    check_val("rst_imm", imm, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    pc_model = 16'h0000;

    exec_instr(16'h0234, 0, 0, 16'h0000, 1'b0, 1'b0);  // ALU rd=4
    exec_instr(16'h0480, 0, 3, 16'h0000, 1'b0, 1'b0);  // LD, dmem_ack after 3 waits
    exec_instr(16'h0C00, 1, 0, 16'h0040, 1'b1, 1'b0);  // JMP taken
    exec_instr(16'h0C00, 0, 0, 16'h0040, 1'b0, 1'b1);  // JMP not taken, stray acks
    exec_instr(16'hB00F, 2, 0, 16'h5555, 1'b1, 1'b1);  // ALU ri=1, negative imm
    exec_instr(16'h0C00, 0, 0, 16'hFFFF, 1'b1, 1'b0);  // jump to 16'hFFFF
    exec_instr(16'h0800, 0, 1, 16'h0000, 1'b0, 1'b1);  // ST at FFFF, pc wraps
    exec_instr(16'h0234, 0, 0, 16'h0000, 1'b0, 1'b0);

    // Reset while waiting in MEM aborts the LD.
    imem_data = 16'h0480; imem_ack = 1'b1; dmem_ack = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && n < 2; k++) begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (dmem_req) n++;
    end
    check_val("mem_reached", n, 2);
    rst = 1'b1;
    @(negedge clk);
    check_val("mrst_reg_we", reg_we, 1'b0);
    check_val("mrst_dmem_req", dmem_req, 1'b0);
    check_val("mrst_pc", pc, 16'h0000);
    check_val("mrst_ld", ld, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_val("mrst_fetch", imem_req, 1'b1);
    check_val("mrst_pc2", pc, 16'h0000);
    check_val("mrst_reg_we2", reg_we, 1'b0);
    pc_model = 16'h0000;

`ifdef CU_HALT_EN
    imem_data = 16'hFFFF; imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (5) @(negedge clk);
    check_val("halt_halted", halted, 1'b1);
    check_val("halt_imem_req", imem_req, 1'b0);
    check_val("halt_dmem_req", dmem_req, 1'b0);
    check_val("halt_reg_we", reg_we, 1'b0);
    check_val("halt_pc", pc, pc_model);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_val("halt_rst", halted, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_val("halt_exit", imem_req, 1'b1);
`else
    exec_instr(16'hFFFF, 0, 0, 16'h1234, 1'b0, 1'b0);  // ordinary JMP, not taken
    check_val("ffff_pc", pc, 16'h0001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
